coin_acceptor: RTL

- Front-end stage that conditions the three raw mechanical coin sensors (1, 5, 10 lei) of the drink vending machine.
- Produces the clean single-cycle coin pulses B1/B5/B10 consumed by the vending FSM.
- Synchronizes and debounces each sensor, detects insertion edges, and admits at most one coin per guard window.
- Returns (REJECT) coins that arrive simultaneously, during the guard window, or while the vending FSM is not accepting coins; keeps a wrap-around audit total of accepted lei.

---
 rtl/coin_acceptor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor: coin sensor front end for the vending FSM.
// Sync, debounce, rise detect, one coin per guard window.
module coin_acceptor #(
    parameter int DEBOUNCE = 4,
    parameter int GAP      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_c1,
    input  logic       raw_c5,
    input  logic       raw_c10,
    input  logic       ready,
    output logic       B1,
    output logic       B5,
    output logic       B10,
    output logic       REJECT,
    output logic       busy,
    output logic [7:0] credit_total
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic {
        S_IDLE,
        S_GAP
    } state_t;

    // channel order: bit0 = 1 leu, bit1 = 5 lei, bit2 = 10 lei
    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    deb;
    logic [2:0]    deb_q;
    logic [2:0]    rise;
    logic [CW-1:0] cnt [3];

    state_t        state_q;
    state_t        state_d;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_d;
    logic [2:0]    b_d;
    logic          rej_d;
    logic [7:0]    coin_val;
    logic [7:0]    credit_d;

    assign raw  = {raw_c10, raw_c5, raw_c1};
    assign rise = deb & ~deb_q;

    // Two-flop sync, then a level only moves after DEBOUNCE agreeing samples
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Value is zero unless exactly one channel rose
    always_comb begin
        case (rise)
            3'b001:  coin_val = 8'd1;
            3'b010:  coin_val = 8'd5;
            3'b100:  coin_val = 8'd10;
            default: coin_val = 8'd0;
        endcase
    end

    // Admission decision: accept a lone coin when idle and ready
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        b_d      = 3'b000;
        rej_d    = 1'b0;
        credit_d = credit_total;
        unique case (state_q)
            S_IDLE: begin
                if (rise != 3'b000) begin
                    if (coin_val != 8'd0 && ready) begin
                        b_d      = rise;
                        credit_d = credit_total + coin_val;
                        state_d  = S_GAP;
                        gap_d    = GW'(GAP);
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                rej_d = |rise;
                if (gap_q == GW'(1)) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gap_d   = '0;
            end
        endcase
    end

    // Registered state and outputs; reset drops any pending pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            gap_q        <= '0;
            B1           <= 1'b0;
            B5           <= 1'b0;
            B10          <= 1'b0;
            REJECT       <= 1'b0;
            busy         <= 1'b0;
            credit_total <= 8'd0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            B1           <= b_d[0];
            B5           <= b_d[1];
            B10          <= b_d[2];
            REJECT       <= rej_d;
            busy         <= (state_d == S_GAP);
            credit_total <= credit_d;
        end
    end

endmodule
